// File: rtl/pc_fetch_control.sv
// Fetch-side PC sequencer: issues instruction requests, fills the IF/DEC register,
// and applies branch-unit redirects, holds and flushes.
typedef struct packed {
  logic        flush;
  logic        hold;
  logic        branch;
  logic        bypass;
  logic [31:0] PCnext;
  logic [31:0] PCcurrent;
} branching_out_t;

module pc_fetch_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           Clock,
  input  logic           nReset,
  input  branching_out_t branching_out,
  output logic [31:0]    imemAddr,
  output logic           imemReq,
  input  logic           imemReady,
  input  logic [31:0]    imemRdata,
  output logic [31:0]    PCIF,
  output logic [31:0]    PCDEC,
  output logic [31:0]    instrDEC,
  output logic           validDEC,
  output logic           targetMisaligned
);

  typedef enum logic [1:0] {RUN, WAIT_MEM, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcdec_q, pcdec_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic        exe_redirect, dec_redirect, redirect, flush_only, hold_only;
  logic        fetch_done;
  logic [31:0] target_raw, target;

  // Event decode; a bare flush outranks a hold since it kills DEC anyway.
  always_comb begin
    exe_redirect = branching_out.flush & (branching_out.bypass | branching_out.branch);
    dec_redirect = ~branching_out.flush & branching_out.branch;
    redirect     = exe_redirect | dec_redirect;
    flush_only   = branching_out.flush & ~branching_out.bypass & ~branching_out.branch;
    hold_only    = branching_out.hold & ~branching_out.flush & ~branching_out.branch;
    if (branching_out.bypass) begin
      target_raw = {branching_out.PCnext[31:1], 1'b0};
    end else begin
      target_raw = branching_out.PCcurrent + branching_out.PCnext;
    end
    target = {target_raw[31:2], 2'b00};
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect with the request still outstanding must swallow the stale response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN, WAIT_MEM: begin
        if (imemReady)     state_d = RUN;
        else if (redirect) state_d = DISCARD;
        else               state_d = WAIT_MEM;
      end
      DISCARD: begin
        if (imemReady) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    imemReq          = nReset & (state_q != DISCARD);
    fetch_done       = imemReq & imemReady;
    targetMisaligned = nReset & redirect & (target_raw[1:0] != 2'b00);
  end

  always_comb begin
    pc_d    = pc_q;
    pcdec_d = pcdec_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
    end else if (flush_only) begin
      valid_d = 1'b0;
    end else if (!hold_only) begin
      valid_d = 1'b0;
      if (fetch_done) begin
        pc_d    = pc_q + 32'd4;
        pcdec_d = pc_q;
        instr_d = imemRdata;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc_q    <= RESET_PC;
      pcdec_q <= 32'h0;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pcdec_q <= pcdec_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign imemAddr = pc_q;
  assign PCIF     = pc_q;
  assign PCDEC    = pcdec_q;
  assign instrDEC = instr_q;
  assign validDEC = valid_q;

endmodule

// File: tb/tb_pc_fetch_control.sv
// Directed bench for pc_fetch_control: each step queues the expected post-edge
// fetch/IF-DEC state and compares it once the edge has been taken.
module tb_pc_fetch_control;

  logic           Clock;
  logic           nReset;
  branching_out_t bo;
  logic [31:0]    imemAddr;
  logic           imemReq;
  logic           imemReady;
  logic [31:0]    imemRdata;
  logic [31:0]    PCIF, PCDEC, instrDEC;
  logic           validDEC, targetMisaligned;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic        req;
    logic        valid;
    logic [31:0] pcdec;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];

  pc_fetch_control dut (
    .Clock           (Clock),
    .nReset          (nReset),
    .branching_out   (bo),
    .imemAddr        (imemAddr),
    .imemReq         (imemReq),
    .imemReady       (imemReady),
    .imemRdata       (imemRdata),
    .PCIF            (PCIF),
    .PCDEC           (PCDEC),
    .instrDEC        (instrDEC),
    .validDEC        (validDEC),
    .targetMisaligned(targetMisaligned)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Instruction memory: word content is a fixed function of its address.
  assign imemRdata = instr_of(imemAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_bo(input logic fl, input logic ho, input logic br, input logic by,
                        input logic [31:0] pn, input logic [31:0] pc);
    bo.flush     = fl;
    bo.hold      = ho;
    bo.branch    = br;
    bo.bypass    = by;
    bo.PCnext    = pn;
    bo.PCcurrent = pc;
  endtask

  task automatic idle();
    set_bo(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic step(input string tag, input logic [31:0] addr, input logic req,
                      input logic valid, input logic [31:0] pcdec, input logic [31:0] instr);
    exp_t e;
    sb.push_back('{tag, addr, req, valid, pcdec, instr});
    @(posedge Clock);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".addr"},  imemAddr, e.addr);
    chk({e.tag, ".pcif"},  PCIF,     e.addr);
    chk({e.tag, ".req"},   {31'h0, imemReq},  {31'h0, e.req});
    chk({e.tag, ".valid"}, {31'h0, validDEC}, {31'h0, e.valid});
    chk({e.tag, ".pcdec"}, PCDEC,    e.pcdec);
    chk({e.tag, ".instr"}, instrDEC, e.instr);
    $display("step %-12s addr=%h req=%b valid=%b pcdec=%h instr=%h",
             e.tag, imemAddr, imemReq, validDEC, PCDEC, instrDEC);
  endtask

  initial begin
    nReset    = 1'b0;
    imemReady = 1'b0;
    // Redirect stimulus during reset must not leak to the outputs.
    set_bo(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0106, 32'h0);
    #12;
    chk("rst.addr",  imemAddr, 32'h0);
    chk("rst.pcif",  PCIF, 32'h0);
    chk("rst.req",   {31'h0, imemReq}, 32'h0);
    chk("rst.valid", {31'h0, validDEC}, 32'h0);
    chk("rst.pcdec", PCDEC, 32'h0);
    chk("rst.instr", instrDEC, 32'h0);
    chk("rst.mis",   {31'h0, targetMisaligned}, 32'h0);
    idle();
    imemReady = 1'b1;
    @(negedge Clock);
    nReset = 1'b1;
    #1;
    chk("rel.req",  {31'h0, imemReq}, 32'h1);
    chk("rel.addr", imemAddr, 32'h0);

    // Zero-wait streaming
    step("run0", 32'h4,  1'b1, 1'b1, 32'h0, instr_of(32'h0));
    step("run1", 32'h8,  1'b1, 1'b1, 32'h4, instr_of(32'h4));
    step("run2", 32'hC,  1'b1, 1'b1, 32'h8, instr_of(32'h8));
    step("run3", 32'h10, 1'b1, 1'b1, 32'hC, instr_of(32'hC));
    step("run4", 32'h14, 1'b1, 1'b1, 32'h10, instr_of(32'h10));

    // Load-use hold at 0x14
    set_bo(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step("hold", 32'h14, 1'b1, 1'b1, 32'h10, instr_of(32'h10));
    idle();
    step("unhold", 32'h18, 1'b1, 1'b1, 32'h14, instr_of(32'h14));

    // Decode redirect: 0x10 + 0x20
    set_bo(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h10);
    #1;
    chk("dec.mis", {31'h0, targetMisaligned}, 32'h0);
    step("dec_redir", 32'h30, 1'b1, 1'b0, 32'h14, instr_of(32'h14));
    idle();
    step("dec_after", 32'h34, 1'b1, 1'b1, 32'h30, instr_of(32'h30));

    // JALR bypass, aligned-after-bit0 and misaligned targets
    set_bo(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0105, 32'h0);
    #1;
    chk("jalr105.mis", {31'h0, targetMisaligned}, 32'h0);
    step("jalr105", 32'h104, 1'b1, 1'b0, 32'h30, instr_of(32'h30));
    idle();
    step("jalr105_nx", 32'h108, 1'b1, 1'b1, 32'h104, instr_of(32'h104));
    set_bo(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0106, 32'h0);
    #1;
    chk("jalr106.mis", {31'h0, targetMisaligned}, 32'h1);
    step("jalr106", 32'h104, 1'b1, 1'b0, 32'h104, instr_of(32'h104));
    idle();
    #1;
    chk("idle.mis", {31'h0, targetMisaligned}, 32'h0);
    step("jalr106_nx", 32'h108, 1'b1, 1'b1, 32'h104, instr_of(32'h104));

    // EXE branch with a wrapping sum: 0x100 + 0xFFFF_FFF0 = 0xF0
    set_bo(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h100);
    step("exe_br", 32'hF0, 1'b1, 1'b0, 32'h104, instr_of(32'h104));
    idle();
    step("exe_br_nx", 32'hF4, 1'b1, 1'b1, 32'hF0, instr_of(32'hF0));

    // Bare flush: bubble, PC unchanged
    set_bo(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("flush", 32'hF4, 1'b1, 1'b0, 32'hF0, instr_of(32'hF0));
    idle();
    step("flush_nx", 32'hF8, 1'b1, 1'b1, 32'hF4, instr_of(32'hF4));

    // Redirect while a request is stalled at 0x8
    set_bo(1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0);
    step("to8", 32'h8, 1'b1, 1'b0, 32'hF4, instr_of(32'hF4));
    idle();
    imemReady = 1'b0;
    step("wait0", 32'h8, 1'b1, 1'b0, 32'hF4, instr_of(32'hF4));
    set_bo(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
    step("wait_redir", 32'h40, 1'b0, 1'b0, 32'hF4, instr_of(32'hF4));
    idle();
    step("discard0", 32'h40, 1'b0, 1'b0, 32'hF4, instr_of(32'hF4));
    imemReady = 1'b1;
    #1;
    chk("discard.req", {31'h0, imemReq}, 32'h0);
    step("stale_drop", 32'h40, 1'b1, 1'b0, 32'hF4, instr_of(32'hF4));
    step("fetch40", 32'h44, 1'b1, 1'b1, 32'h40, instr_of(32'h40));

    // Back-to-back redirects in DISCARD: the last one wins
    imemReady = 1'b0;
    step("wait44", 32'h44, 1'b1, 1'b0, 32'h40, instr_of(32'h40));
    set_bo(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
    step("redir200", 32'h200, 1'b0, 1'b0, 32'h40, instr_of(32'h40));
    set_bo(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h0);
    step("redir300", 32'h300, 1'b0, 1'b0, 32'h40, instr_of(32'h40));
    idle();
    imemReady = 1'b1;
    step("stale2", 32'h300, 1'b1, 1'b0, 32'h40, instr_of(32'h40));
    step("fetch300", 32'h304, 1'b1, 1'b1, 32'h300, instr_of(32'h300));

    // PC wrap
    set_bo(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    step("to_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h300, instr_of(32'h300));
    idle();
    step("wrap", 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC));
    step("post_wrap", 32'h4, 1'b1, 1'b1, 32'h0, instr_of(32'h0));

    // Reset pulse while stalled in WAIT_MEM
    imemReady = 1'b0;
    step("wait4", 32'h4, 1'b1, 1'b0, 32'h0, instr_of(32'h0));
    nReset = 1'b0;
    #1;
    chk("rst2.addr",  imemAddr, 32'h0);
    chk("rst2.req",   {31'h0, imemReq}, 32'h0);
    chk("rst2.valid", {31'h0, validDEC}, 32'h0);
    chk("rst2.pcdec", PCDEC, 32'h0);
    chk("rst2.instr", instrDEC, 32'h0);
    imemReady = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    chk("rst2.hold_addr", imemAddr, 32'h0);
    nReset = 1'b1;
    #1;
    chk("rel2.req",  {31'h0, imemReq}, 32'h1);
    chk("rel2.addr", imemAddr, 32'h0);
    step("rel2_run0", 32'h4, 1'b1, 1'b1, 32'h0, instr_of(32'h0));
    step("rel2_run1", 32'h8, 1'b1, 1'b1, 32'h4, instr_of(32'h4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
